// File: rtl/add64_seq.sv
// add64_seq: splits a 64-bit add into two passes through an external
// registered 32-bit adder, low halves first, then high halves with the
// low-half carry chained in. Produces a 64-bit sum, a carry-out and a
// one-cycle done pulse.
module add64_seq #(
   parameter int ADD_LAT = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   input  logic        ci,
   output logic        busy,
   output logic        done,
   output logic [63:0] sum,
   output logic        co,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_ci,
   input  logic [31:0] add_s,
   input  logic        add_co
);

   // Phase counter width: enough to count 0..ADD_LAT, never less than one bit.
   localparam int CW = (ADD_LAT + 1 > 2) ? $clog2(ADD_LAT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ADD_LAT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]    state_q,  state_d;
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [31:0]   a_hi_q,   a_hi_d;
   logic [31:0]   b_hi_q,   b_hi_d;
   logic [31:0]   sum_lo_q, sum_lo_d;
   logic [63:0]   sum_q,    sum_d;
   logic          co_q,     co_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;
   logic [31:0]   add_a_q,  add_a_d;
   logic [31:0]   add_b_q,  add_b_d;
   logic          add_ci_q, add_ci_d;

   logic          accept_s;
   logic          last_s;

   // A request is only taken when no operation is in flight (IDLE or DONE).
   assign accept_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign last_s   = (cnt_q == CNT_LAST);

   // Next-state and datapath decode. The adder inputs are registered so they
   // are already valid in the first cycle of each phase; the latched carry-in
   // and later the low-half carry live directly in add_ci_q.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_hi_d   = a_hi_q;
      b_hi_d   = b_hi_q;
      sum_lo_d = sum_lo_q;
      sum_d    = sum_q;
      co_d     = co_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      add_ci_d = add_ci_q;
      if (accept_s) begin
         state_d  = ST_LO;
         cnt_d    = {CW{1'b0}};
         a_hi_d   = op_a[63:32];
         b_hi_d   = op_b[63:32];
         add_a_d  = op_a[31:0];
         add_b_d  = op_b[31:0];
         add_ci_d = ci;
         busy_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               busy_d = 1'b0;
            end
            ST_LO: begin
               if (last_s) begin
                  state_d  = ST_HI;
                  cnt_d    = {CW{1'b0}};
                  sum_lo_d = add_s;
                  add_a_d  = a_hi_q;
                  add_b_d  = b_hi_q;
                  add_ci_d = add_co;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_HI: begin
               if (last_s) begin
                  state_d  = ST_DONE;
                  cnt_d    = {CW{1'b0}};
                  sum_d    = {add_s, sum_lo_q};
                  co_d     = add_co;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  add_a_d  = 32'd0;
                  add_b_d  = 32'd0;
                  add_ci_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d  = ST_IDLE;
               cnt_d    = {CW{1'b0}};
               busy_d   = 1'b0;
               add_a_d  = 32'd0;
               add_b_d  = 32'd0;
               add_ci_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {CW{1'b0}};
         a_hi_q   <= 32'd0;
         b_hi_q   <= 32'd0;
         sum_lo_q <= 32'd0;
         sum_q    <= 64'd0;
         co_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         add_a_q  <= 32'd0;
         add_b_q  <= 32'd0;
         add_ci_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_hi_q   <= a_hi_d;
         b_hi_q   <= b_hi_d;
         sum_lo_q <= sum_lo_d;
         sum_q    <= sum_d;
         co_q     <= co_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         add_a_q  <= add_a_d;
         add_b_q  <= add_b_d;
         add_ci_q <= add_ci_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign sum    = sum_q;
   assign co     = co_q;
   assign add_a  = add_a_q;
   assign add_b  = add_b_q;
   assign add_ci = add_ci_q;

endmodule

// File: tb/tb_add64_seq.sv
// Testbench for add64_seq with a 1-stage registered 32-bit adder model.
// Expected 65-bit results are queued at acceptance and compared at done.
module tb_add64_seq;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        ci;
   logic        busy;
   logic        done;
   logic [63:0] sum;
   logic        co;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_ci;
   logic [31:0] add_s;
   logic        add_co;

   int n_chk  = 0;
   int n_fail = 0;

   // Bench-side model of the sequencer.
   logic [64:0] exp_q[$];
   int          m_cnt;
   logic        m_done;
   logic [63:0] m_a, m_b;
   logic        m_ci;
   logic [63:0] m_sum;
   logic        m_co;
   int          cyc;
   int          acc_cyc;
   int          last_done_cyc;
   bit          cont_mode;

   add64_seq #(.ADD_LAT(1)) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .op_a(op_a), .op_b(op_b), .ci(ci),
      .busy(busy), .done(done), .sum(sum), .co(co),
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
      .add_s(add_s), .add_co(add_co)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One-stage registered 32-bit ripple adder feeding back into the DUT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         {add_co, add_s} <= 33'd0;
      end else begin
         {add_co, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, update the model from the sampled inputs, then check.
   task automatic tick();
      logic [32:0] lo;
      logic [31:0] ea, eb;
      logic        eci;
      logic [64:0] e;
      @(posedge clock);
      m_done = 1'b0;
      if (!reset_n) begin
         m_cnt = 0;
      end else if (m_cnt == 0 && start) begin
         m_a = op_a; m_b = op_b; m_ci = ci;
         exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {64'd0, ci});
         m_cnt = 4;
         acc_cyc = cyc + 1;
      end else if (m_cnt != 0) begin
         if (m_cnt == 1) m_done = 1'b1;
         m_cnt--;
      end
      cyc++;
      #1;
      lo = {1'b0, m_a[31:0]} + {1'b0, m_b[31:0]} + {32'd0, m_ci};
      if (m_cnt >= 3) begin
         ea = m_a[31:0]; eb = m_b[31:0]; eci = m_ci;
      end else if (m_cnt >= 1) begin
         ea = m_a[63:32]; eb = m_b[63:32]; eci = lo[32];
      end else begin
         ea = 32'd0; eb = 32'd0; eci = 1'b0;
      end
      chk("busy", {127'd0, busy}, {127'd0, (m_cnt != 0)});
      chk("done", {127'd0, done}, {127'd0, m_done});
      chk("add_a", {96'd0, add_a}, {96'd0, ea});
      chk("add_b", {96'd0, add_b}, {96'd0, eb});
      chk("add_ci", {127'd0, add_ci}, {127'd0, eci});
      if (done) begin
         chk("latency", 128'(cyc - acc_cyc), 128'd4);
         if (cont_mode && last_done_cyc >= 0) chk("spacing", 128'(cyc - last_done_cyc), 128'd5);
         last_done_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("spurious_done", 128'd1, 128'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sum", {64'd0, sum}, {64'd0, e[63:0]});
            chk("co", {127'd0, co}, {127'd0, e[64]});
            m_sum = e[63:0];
            m_co  = e[64];
         end
      end else begin
         chk("sum_hold", {64'd0, sum}, {64'd0, m_sum});
         chk("co_hold", {127'd0, co}, {127'd0, m_co});
      end
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c);
      op_a = a; op_b = b; ci = c; start = 1'b1;
      tick();
      start = 1'b0;
      op_a = ~a; op_b = ~b; ci = ~c;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      chk("drain", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
      chk({tag, "_done"}, {127'd0, done}, 128'd0);
      chk({tag, "_sum"}, {64'd0, sum}, 128'd0);
      chk({tag, "_co"}, {127'd0, co}, 128'd0);
      chk({tag, "_add_a"}, {96'd0, add_a}, 128'd0);
      chk({tag, "_add_b"}, {96'd0, add_b}, 128'd0);
      chk({tag, "_add_ci"}, {127'd0, add_ci}, 128'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op_a = 64'd0; op_b = 64'd0; ci = 1'b0;
      m_cnt = 0; m_done = 1'b0; m_a = 64'd0; m_b = 64'd0; m_ci = 1'b0;
      m_sum = 64'd0; m_co = 1'b0; cyc = 0; acc_cyc = 0; last_done_cyc = -1;
      cont_mode = 1'b0;
      #3;
      chk_all_zero("reset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Directed operations.
      run_op(64'd0, 64'd0, 1'b0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
      run_op(64'h135F_A562_135F_A562, 64'h3561_4642_3561_4642, 1'b0);
      chk("directed_sum", {64'd0, sum}, {64'd0, 64'h48C0_EBA4_48C0_EBA4});
      tick();

      // Continuous start with operands changing every cycle.
      cont_mode = 1'b1;
      last_done_cyc = -1;
      start = 1'b1;
      for (int i = 0; i < 26; i++) begin
         op_a = {$urandom(), $urandom()};
         op_b = {$urandom(), $urandom()};
         ci   = 1'($urandom_range(1, 0));
         if (i == 3) begin
            op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'hFFFF_FFFF_FFFF_FFFF; ci = 1'b1;
         end
         tick();
      end
      start = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      chk("cont_drain", 128'(exp_q.size()), 128'd0);
      cont_mode = 1'b0;
      tick();

      // Reset during the HI phase discards the operation.
      op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'd1; ci = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      exp_q.delete();
      m_cnt = 0; m_sum = 64'd0; m_co = 1'b0; m_a = 64'd0; m_b = 64'd0; m_ci = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("post_reset_sum", {64'd0, sum}, 128'd0);
      run_op(64'd2, 64'd3, 1'b0);
      chk("final_sum", {64'd0, sum}, 128'd5);
      chk("final_co", {127'd0, co}, 128'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/add64_seq.md
# add64_seq

Two-pass 64-bit addition sequencer wrapped around the registered 32-bit ripple-carry adder stage. Accepts a 64-bit operand pair on a start pulse and drives the low halves into the adder, then the high halves with the low-half carry chained in. Collects both 32-bit results into a 64-bit sum with a one-cycle done pulse. Sits directly upstream of the adder, which it feeds, and directly downstream of it, since it consumes the adder's sum and carry.

## Interface
- ADD_LAT, 1, adder latency in cycles, ≥1. A result for inputs presented in cycle k is valid on add_s/add_co in cycle k+ADD_LAT.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled at rising edge while not busy
- op_a  in  64  operand A; latched on accepted start
- op_b  in  64  operand B; latched on accepted start
- ci  in  1  carry-in; latched on accepted start
- busy  out  1  high in LO and HI states
- done  out  1  one-cycle pulse; sum/co valid
- sum  out  64  result; held until next completion
- co  out  1  64-bit carry-out; held with sum
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_ci  out  1  adder carry-in
- add_s  in  32  adder sum
- add_co  in  1  adder carry-out

## Operation
- States: IDLE, LO, HI, DONE.
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - busy, done, sum, co, add_a, add_b, add_ci and the phase counter all go to 0.
  - An in-flight operation is discarded and no done is produced.
- IDLE, start=1 at an edge:
  - Latch op_a, op_b, ci.
  - Go to LO and clear the phase counter.
- LO:
  - Drive add_a=A[31:0], add_b=B[31:0], add_ci=latched ci, held stable for ADD_LAT+1 cycles.
  - On the last edge of that window, capture add_s into sum_lo and add_co into carry_lo, then go to HI.
- HI:
  - Drive add_a=A[63:32], add_b=B[63:32], add_ci=carry_lo for ADD_LAT+1 cycles.
  - On the last edge, load sum={add_s, sum_lo}, load co=add_co, set done, and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 at this edge, latch new operands and go to LO (back-to-back). Otherwise go to IDLE.
- start in LO or HI is ignored, with no queueing. Operand changes after acceptance have no effect.
- add_a, add_b and add_ci are 0 in IDLE and DONE.
- Arithmetic is mod 2^64. co is bit 64 of op_a+op_b+ci.

## Timing
- Latency from the accepted start edge E0 to done: 2·(ADD_LAT+1) cycles.
  - With ADD_LAT=1, done is high in the cycle after edge E4.
- Throughput with continuous start: one result every 2·ADD_LAT+3 cycles. The accepting DONE cycle overlaps with the next request.
- busy rises in the cycle after E0 and falls in the DONE cycle.
- sum and co update only at the edge that raises done.
- The phase counter is ceil(log2(ADD_LAT+1)) bits, min 1, and wraps to 0 at each phase change.
- Reset asserted mid-cycle takes effect immediately (async). Release is synchronous to the next edge; the first possible start is accepted at the first edge after release.

## Test plan
- Bench model: ADD_LAT=1, adder is a 1-stage registered 32-bit adder. Checks compare against a 65-bit reference sum.
- After reset: busy=0, done=0, sum=0, co=0, add_a=0. Then start with a=0, b=0, ci=0 → done 4 cycles after start, sum=0, co=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, ci=1 → add_ci=1 during HI; sum=64'h0, co=1.
- a=64'h0000_0000_FFFF_FFFF, b=64'h1, ci=0 → sum=64'h0000_0001_0000_0000, co=0.
- a=64'h135F_A562_135F_A562, b=64'h3561_4642_3561_4642, ci=0 → sum=64'h48C0_EBA4_48C0_EBA4, co=0.
- start held high continuously with operands changing every cycle:
  - Only the operands at accepting edges are used.
  - done pulses are 5 cycles apart.
  - Each result matches the operands latched at its own acceptance.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 for 1 cycle during HI of an add with a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ci=0.
  - All outputs go to 0 immediately, no done follows, and sum stays 0.
  - A subsequent add with a=2, b=3, ci=0 yields sum=5, co=0.
